// File: rtl/clk_div_multi.sv
// clk_div_multi -- NCH independent, runtime-programmable clock dividers.
//
// Each channel divides clk_i by 2*half. clk_o has a 50% duty cycle.
// tick_o is a one-cycle strobe in the first cycle of each clk_o high phase.
// A new half-period is written through a valid/ready port into a per-channel
// shadow register. A running channel applies it only at the end of a full
// period (on the 1->0 edge of clk_o). A disabled channel applies it on the
// next edge. Either way, clk_o never shows a period built from two divisors.
//
// Optional feature: define CLKDIV_SYNC_EN to add sync_i. A one-cycle pulse
// on sync_i phase-aligns every enabled channel.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   en_i[NCH]           per-channel run enable
//   cfg_valid_i/ready_o divisor write handshake (ready = target has no pending value)
//   cfg_ch_i            target channel; out-of-range writes are accepted and dropped
//   cfg_div_i           new half-period in clk_i cycles (0 is stored as 1)
//   sync_i              phase-align strobe (CLKDIV_SYNC_EN only)
//   clk_o[NCH]          divided clocks, registered
//   tick_o[NCH]         once-per-period strobes, registered

module clk_div_multi_ch #(
  parameter int CW        = 32,
  parameter int DIV_RESET = 10_000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic          wr_i,
  input  logic [CW-1:0] wr_div_i,
  output logic          clk_o,
  output logic          tick_o,
  output logic          pend_v_o
);

  localparam logic [CW-1:0] HALF_RST = CW'(DIV_RESET);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          term;

  // half_q is never 0, so half_q-1 cannot underflow.
  // cnt_q stays at or below half_q-1, so the +1 below never wraps.
  assign term = (cnt_q == half_q - CW'(1));

  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_v_q) begin
        half_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (sync_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_v_q) begin
        half_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (term) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      // Apply only at the high->low toggle, which is the full-period boundary.
      if (clk_q && pend_v_q) begin
        half_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // A new write lands in the shadow after any apply in the same cycle.
    if (wr_i) begin
      pend_d   = wr_div_i;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      half_q   <= HALF_RST;
      pend_q   <= HALF_RST;
      pend_v_q <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_o    = clk_q;
  assign tick_o   = tick_q;
  assign pend_v_o = pend_v_q;

endmodule

module clk_div_multi #(
  parameter int NCH       = 4,
  parameter int CW        = 32,
  parameter int DIV_RESET = 10_000,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NCH-1:0] en_i,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  input  logic [CHW-1:0] cfg_ch_i,
  input  logic [CW-1:0]  cfg_div_i,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync_i,
`endif
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] tick_o
);

  localparam int NPAD = 1 << CHW;

  logic [NCH-1:0]  pend_v;
  logic [NPAD-1:0] pend_v_pad;
  logic            cfg_fire;
  logic [CW-1:0]   wr_div;
  logic            sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channel slots read as "not pending".
  // Writes to them are therefore always ready, and no channel decodes them.
  always_comb begin
    pend_v_pad          = '0;
    pend_v_pad[NCH-1:0] = pend_v;
  end

  assign cfg_ready_o = ~pend_v_pad[cfg_ch_i];
  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign wr_div      = (cfg_div_i == '0) ? CW'(1) : cfg_div_i;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    clk_div_multi_ch #(
      .CW        (CW),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[k]),
      .sync_i   (sync_w),
      .wr_i     (cfg_fire && (cfg_ch_i == CHW'(k))),
      .wr_div_i (wr_div),
      .clk_o    (clk_o[k]),
      .tick_o   (tick_o[k]),
      .pend_v_o (pend_v[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi (NCH=5, so channel numbers 5..7 are out of range).
// The reference model tracks, per channel, the position n within the full
// period (0..2*half-1). Expected outputs are clk = (n >= half) and tick = (n == half).
module tb_clk_div_multi;
  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int DR  = 4;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           valid = 1'b0;
  logic [CHW-1:0] ch = '0;
  logic [CW-1:0]  div = '0;
  logic           sync = 1'b0;
  logic           ready;
  logic [NCH-1:0] clk_o, tick_o;

  always #5 clk = ~clk;

  clk_div_multi #(.NCH(NCH), .CW(CW), .DIV_RESET(DR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .cfg_valid_i (valid),
    .cfg_ready_o (ready),
    .cfg_ch_i    (ch),
    .cfg_div_i   (div),
`ifdef CLKDIV_SYNC_EN
    .sync_i      (sync),
`endif
    .clk_o       (clk_o),
    .tick_o      (tick_o)
  );

  int checks = 0;
  int failures = 0;

  int n[NCH];
  int half[NCH];
  int pend[NCH];
  bit pv[NCH];
  logic [2*NCH-1:0] expq[$];

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      n[k] = 0; half[k] = DR; pend[k] = DR; pv[k] = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // One clock cycle: set inputs at negedge, check ready, advance the model,
  // and queue the outputs expected after the following posedge.
  task automatic drive(input logic [NCH-1:0] e, input logic v, input int c, input int d, input logic s);
    logic [NCH-1:0] ec, et;
    bit mr, fire, se;
    @(negedge clk);
    en = e; valid = v; ch = c[CHW-1:0]; div = d[CW-1:0]; sync = s;
    #1;
    if (c >= NCH) mr = 1'b1;
    else mr = !pv[c];
    chk("cfg_ready", {31'd0, ready}, {31'd0, mr});
    fire = v && mr;
`ifdef CLKDIV_SYNC_EN
    se = s;
`else
    se = 1'b0;
`endif
    for (int k = 0; k < NCH; k++) begin
      if (!e[k] || se) begin
        n[k] = 0;
        if (pv[k]) begin half[k] = pend[k]; pv[k] = 1'b0; end
      end else begin
        n[k]++;
        if (n[k] == 2 * half[k]) begin
          n[k] = 0;
          if (pv[k]) begin half[k] = pend[k]; pv[k] = 1'b0; end
        end
      end
      if (fire && c == k) begin
        pend[k] = (d == 0) ? 1 : d;
        pv[k] = 1'b1;
      end
      ec[k] = (n[k] >= half[k]);
      et[k] = (n[k] == half[k]);
    end
    expq.push_back({ec, et});
  endtask

  // Monitor: every posedge while out of reset, compare against the queued expectation.
  initial begin
    logic [2*NCH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if ({clk_o, tick_o} !== e) begin
          failures++;
          $display("FAIL outputs clk/tick got=%b/%b want=%b/%b t=%0t",
                   clk_o, tick_o, e[2*NCH-1:NCH], e[NCH-1:0], $time);
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0] re;
    int b, wk, i;
    model_reset();
    #1;
    chk("reset_clk", {27'd0, clk_o}, 32'd0);
    chk("reset_tick", {27'd0, tick_o}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // First rise exactly on the 4th edge, with tick in that cycle only.
    repeat (3) drive('1, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("first_rise_early", {27'd0, clk_o}, 32'd0);
    drive('1, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("first_rise_clk", {27'd0, clk_o}, 32'h1f);
    chk("first_rise_tick", {27'd0, tick_o}, 32'h1f);
    drive('1, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("tick_single", {27'd0, tick_o}, 32'd0);
    repeat (25) drive('1, 0, 0, 0, 0);

    // Write D=2 to ch1 in the middle of its high phase, then try to overwrite it while stalled.
    for (i = 0; i < 20 && n[1] != half[1] + 1; i++) drive('1, 0, 0, 0, 0);
    chk("reach_mid_high", {31'd0, n[1] == half[1] + 1}, 32'd1);
    drive('1, 1, 1, 2, 0);
    repeat (6) drive('1, 1, 1, 3, 0);
    repeat (24) drive('1, 0, 1, 0, 0);

    // Write D=0 to ch2 while it is disabled, then enable it.
    drive(5'b11011, 1, 2, 0, 0);
    repeat (2) drive(5'b11011, 0, 2, 0, 0);
    repeat (12) drive('1, 0, 2, 0, 0);

    // Drop ch0 while its clk is high, then re-enable it.
    for (i = 0; i < 20 && n[0] < half[0]; i++) drive('1, 0, 0, 0, 0);
    chk("reach_ch0_high", {31'd0, n[0] >= half[0]}, 32'd1);
    repeat (3) drive(5'b11110, 0, 0, 0, 0);
    repeat (12) drive('1, 0, 0, 0, 0);

    // Randomized traffic.
    re = '1;
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(15) == 0) begin
        b = $urandom_range(NCH - 1);
        re[b] = ~re[b];
      end
      drive(re, $urandom_range(2) == 0, $urandom_range(7), $urandom_range(4),
            $urandom_range(39) == 0);
    end

    // Asynchronous reset in mid-period while a write is pending.
    for (i = 0; i < 40; i++) begin
      wk = $urandom_range(NCH - 1);
      if (!pv[wk]) break;
      drive('1, 0, 0, 0, 0);
    end
    drive('1, 1, wk, 2, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    expq.delete();
    model_reset();
    #1;
    chk("async_rst_clk", {27'd0, clk_o}, 32'd0);
    chk("async_rst_tick", {27'd0, tick_o}, 32'd0);
    @(posedge clk); #4;
    rst_n = 1'b1;
    repeat (20) drive('1, 0, wk, 0, 0);

`ifdef CLKDIV_SYNC_EN
    // ch0 and ch3 at half=3 but out of phase, then a sync pulse.
    drive('0, 1, 0, 3, 0);
    drive('0, 1, 3, 3, 0);
    repeat (2) drive('0, 0, 0, 0, 0);
    repeat (2) drive(5'b00001, 0, 0, 0, 0);
    repeat (4) drive(5'b01001, 0, 0, 0, 0);
    drive(5'b01001, 0, 0, 0, 1);
    repeat (10) drive(5'b01001, 0, 0, 0, 0);
`endif

    @(posedge clk); #3;
    chk("queue_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-programmable clock divider for the MemoriaRAM design and later projects. It generalises the fixed-ratio divider into NCH independent channels. Each channel has a per-channel enable, a loadable half-period, and a one-cycle `tick_o` strobe for logic that stays on `clk_i`. Divisor updates pass through a valid/ready port and are applied glitch-free, only at a period boundary.

## Interface
- `NCH`, 4: number of divider channels (1..16).
- `CW`, 32: counter and divisor width in bits.
- `DIV_RESET`, 10_000: half-period (in `clk_i` cycles) loaded into every channel at reset; must be ≥1.
- `clk_i` in 1: the only clock; all logic is rising-edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `en_i` in NCH: per-channel run enable.
- `cfg_valid_i` in 1: divisor write request.
- `cfg_ready_o` out 1: write accepted when high together with `cfg_valid_i`.
- `cfg_ch_i` in max(1,$clog2(NCH)): target channel of the write.
- `cfg_div_i` in CW: new half-period D, in `clk_i` cycles.
- `sync_i` in 1: phase-align all channels; present only with `CLKDIV_SYNC_EN`.
- `clk_o` out NCH: divided clocks, registered.
- `tick_o` out NCH: one-cycle strobes, registered.

## Operation
- Per-channel state:
  - `cnt` (CW bits).
  - Active half-period `half` (CW bits).
  - Shadow `pend` (CW bits) plus `pend_v` flag.
  - Output registers `clk_o` and `tick_o`.
- Running channel (`en_i[k]`=1):
  - `cnt` counts 0..`half`-1.
  - At the terminal count (`cnt`==`half`-1): `cnt`←0 and `clk_o[k]` toggles.
  - Every other cycle: `cnt`←`cnt`+1.
  - Output period = 2·`half` `clk_i` cycles, 50% duty.
- `tick_o[k]`=1 exactly in the cycle in which `clk_o[k]` is 1 for the first time, i.e. once per period; otherwise 0.
- Disabled channel (`en_i[k]`=0):
  - Next edge: `cnt`←0, `clk_o[k]`←0, `tick_o[k]`←0.
  - Held there until re-enabled.
  - On re-enable, the first rising `clk_o` occurs `half` cycles after the first enabled edge.
- Configuration port:
  - `cfg_ready_o` = ~`pend_v[cfg_ch_i]`, combinational.
  - A transfer occurs when `cfg_valid_i` and `cfg_ready_o` are both 1.
  - On transfer: `pend`←`cfg_div_i`, with 0 stored as 1, and `pend_v`←1.
  - `cfg_ch_i` ≥ NCH: transfer is accepted (ready=1) and discarded.
- Applying a pending value:
  - Running channel: applied at the terminal count where `clk_o` goes 1→0 (end of a full period). There, `half`←`pend`, `pend_v`←0, `cnt`←0.
  - Disabled channel: applied on the next edge.
  - A partial period with mixed divisors never appears on `clk_o`.
- Simultaneous events:
  - A transfer in the same cycle as that channel's apply point goes to `pend` only. It is applied at the following full-period boundary; the old `pend` value is applied this cycle.
  - A transfer and an `en_i` deassert in the same cycle: the value is stored and applied on the next edge.
- Arithmetic: `cnt` never exceeds `half`-1, so no wrap is possible. `half`=2^CW−1 is legal.

## Timing
- Reset values, asynchronously on `rst_ni`=0:
  - `cnt`=0, `half`=DIV_RESET, `pend_v`=0.
  - `clk_o`=0, `tick_o`=0 for all channels.
- After `rst_ni` rises, if `en_i[k]`=1 from the first edge: `clk_o[k]` and `tick_o[k]` rise after `half` edges.
- Reset mid-operation aborts all periods and discards pending writes.
- Write-to-effect latency:
  - Disabled channel: 1 cycle.
  - Running channel: ≤ 2·`half_old` cycles.
- Multiple channels may be written in back-to-back cycles. A second write to the same channel stalls (ready=0) until its pending value is applied.
- Both outputs are straight from flops. `clk_o` is intended for low-speed external or peripheral use; internal logic must use `tick_o` as an enable.

## Configuration
- `CLKDIV_SYNC_EN` defined:
  - Port `sync_i` exists.
  - `sync_i`=1 for one cycle sets, on the next edge, every enabled channel to `cnt`←0, `clk_o`←0, `tick_o`←0.
  - Any pending value is applied immediately (`pend_v`←0).
  - Afterwards all channels with equal `half` toggle in lockstep.
  - `sync_i` takes priority over the normal terminal count.
  - Disabled channels are unaffected.
- Not defined: no `sync_i` port and no sync logic; all other behaviour is identical.

## Test plan
- Reset with `DIV_RESET`=4, all `en_i`=1 → every `clk_o` has period 8 cycles, 4 high/4 low. First rise on the 4th edge after reset release, with `tick_o` high only in that cycle.
- Channel 1 at `half`=4, running: write D=2 mid-high-phase → current period finishes at 8 cycles, subsequent periods are 4. `cfg_ready_o` for ch1 is 0 until the apply point.
- Write D=0 to channel 2 while disabled → applied next cycle as `half`=1. On enable, `clk_o[2]` toggles every cycle (f/2) and `tick_o[2]` is high every other cycle.
- Drop `en_i[0]` while `clk_o[0]`=1 → `clk_o[0]`=0 the next cycle. Re-enable → first rise exactly `half` cycles later.
- Assert `rst_ni`=0 asynchronously mid-period with a pending write → all outputs 0 immediately. After release `half`=DIV_RESET and the pending write is lost.
- With `CLKDIV_SYNC_EN`, ch0 `half`=3 and ch3 `half`=3 out of phase: pulse `sync_i` → both `clk_o` go 0 next cycle, then rise together 3 cycles later.
